// File: rtl/pe_pkg.sv
// pe_pkg: shared PE constants, operator opcodes and the issue instruction payload.
//   DATA_L             operand / result width
//   OPCODE_L           operator opcode width
//   PRECISION_CONFIG_L operator precision field width (wired by the parent)
//   INSTR_ADDR_L       register address container width inside pe_instr_t
package pe_pkg;

  localparam int unsigned DATA_L             = 32;
  localparam int unsigned OPCODE_L           = 3;
  localparam int unsigned PRECISION_CONFIG_L = 2;

  // Wide enough for any register file up to 256 entries; narrower files zero-extend.
  localparam int unsigned INSTR_ADDR_L = 8;

  typedef enum logic [OPCODE_L-1:0] {
    OP_SUM  = 3'd0,
    OP_PROD = 3'd1,
    OP_PASS = 3'd2,
    OP_MAX  = 3'd3,
    OP_MIN  = 3'd4
  } pe_opcode_e;

  // Opcode is kept as raw bits so unrecognised encodings pass through untouched.
  typedef struct packed {
    logic [OPCODE_L-1:0]     opcode;
    logic [INSTR_ADDR_L-1:0] src0;
    logic [INSTR_ADDR_L-1:0] src1;
    logic [INSTR_ADDR_L-1:0] dst;
    logic                    store;
  } pe_instr_t;

endpackage

// File: rtl/pe_regfile.sv
// pe_regfile: REG_N x DATA_L operand registers.
//   clk_i, rst_i          clock, synchronous active-high reset (clears every entry)
//   rd0_*/rd1_*           two asynchronous read ports
//   ld_we_i/addr/data     external load write port
//   wb_we_i/addr/data     writeback write port
module pe_regfile
  import pe_pkg::*;
#(
  parameter int unsigned REG_N      = 16,
  parameter int unsigned REG_ADDR_L = $clog2(REG_N)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [REG_ADDR_L-1:0] rd0_addr_i,
  output logic [DATA_L-1:0]     rd0_data_o,
  input  logic [REG_ADDR_L-1:0] rd1_addr_i,
  output logic [DATA_L-1:0]     rd1_data_o,
  input  logic                  ld_we_i,
  input  logic [REG_ADDR_L-1:0] ld_addr_i,
  input  logic [DATA_L-1:0]     ld_data_i,
  input  logic                  wb_we_i,
  input  logic [REG_ADDR_L-1:0] wb_addr_i,
  input  logic [DATA_L-1:0]     wb_data_i
);

  logic [DATA_L-1:0] mem_q [REG_N];
  logic [DATA_L-1:0] mem_d [REG_N];

  // Write merge; the issue controller never enables both ports together, WB wins if it did.
  always_comb begin
    mem_d = mem_q;
    if (ld_we_i) begin
      mem_d[ld_addr_i] = ld_data_i;
    end
    if (wb_we_i) begin
      mem_d[wb_addr_i] = wb_data_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd0_data_o = mem_q[rd0_addr_i];
  assign rd1_data_o = mem_q[rd1_addr_i];

endmodule

// File: rtl/pe_issue_ctrl.sv
// pe_issue_ctrl: two-stage (EX, WB) issue pipeline in front of a combinational PE operator.
//   clk_i, rst_i            clock, synchronous active-high reset
//   instr_*                 instruction valid/ready handshake and fields
//   ld_*                    external register load, accepted only with an empty pipeline
//   op_in_0_o/op_in_1_o/op_opcode_o, op_out_i   operator drive and its combinational result
//   res_*                   result stream for instructions marked store
//   busy_o                  EX or WB holds an instruction
// The handshake outputs and the gated reset view are combinational from state and inputs.
module pe_issue_ctrl
  import pe_pkg::*;
#(
  parameter int unsigned REG_N      = 16,
  parameter int unsigned REG_ADDR_L = $clog2(REG_N)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  instr_vld_i,
  output logic                  instr_rdy_o,
  input  logic [OPCODE_L-1:0]   instr_opcode_i,
  input  logic [REG_ADDR_L-1:0] instr_src0_i,
  input  logic [REG_ADDR_L-1:0] instr_src1_i,
  input  logic [REG_ADDR_L-1:0] instr_dst_i,
  input  logic                  instr_store_i,
  input  logic                  ld_vld_i,
  output logic                  ld_rdy_o,
  input  logic [REG_ADDR_L-1:0] ld_addr_i,
  input  logic [DATA_L-1:0]     ld_data_i,
  output logic [DATA_L-1:0]     op_in_0_o,
  output logic [DATA_L-1:0]     op_in_1_o,
  output logic [OPCODE_L-1:0]   op_opcode_o,
  input  logic [DATA_L-1:0]     op_out_i,
  output logic                  res_vld_o,
  input  logic                  res_rdy_i,
  output logic [DATA_L-1:0]     res_data_o,
  output logic [REG_ADDR_L-1:0] res_dst_o,
  output logic                  busy_o
);

  // EX stage
  logic      ex_vld_q, ex_vld_d;
  pe_instr_t ex_instr_q, ex_instr_d;

  // WB stage
  logic                  wb_vld_q, wb_vld_d;
  logic                  wb_store_q, wb_store_d;
  logic [DATA_L-1:0]     wb_data_q, wb_data_d;
  logic [REG_ADDR_L-1:0] wb_dst_q, wb_dst_d;

  logic                  stall_c;
  logic                  accept_c;
  logic                  retire_c;
  logic                  ld_we_c;
  pe_instr_t             instr_c;
  logic [REG_ADDR_L-1:0] ex_src0_c, ex_src1_c, ex_dst_c;
  logic [DATA_L-1:0]     rf_rd0_c, rf_rd1_c;
  logic [DATA_L-1:0]     opnd0_c, opnd1_c;
  logic                  unused_addr_hi_c;

  // Handshake control: only a store result blocked by the sink can stall the pipe.
  assign stall_c     = wb_vld_q && wb_store_q && !res_rdy_i;
  assign instr_rdy_o = !rst_i && !stall_c;
  assign accept_c    = instr_vld_i && instr_rdy_o;
  assign retire_c    = !rst_i && wb_vld_q && !stall_c;
  assign ld_rdy_o    = !rst_i && !ex_vld_q && !wb_vld_q && !instr_vld_i;
  assign ld_we_c     = ld_vld_i && ld_rdy_o;

  // Pack the offered instruction into the shared payload format.
  always_comb begin
    instr_c        = '0;
    instr_c.opcode = instr_opcode_i;
    instr_c.src0   = INSTR_ADDR_L'(instr_src0_i);
    instr_c.src1   = INSTR_ADDR_L'(instr_src1_i);
    instr_c.dst    = INSTR_ADDR_L'(instr_dst_i);
    instr_c.store  = instr_store_i;
  end

  assign ex_src0_c = REG_ADDR_L'(ex_instr_q.src0);
  assign ex_src1_c = REG_ADDR_L'(ex_instr_q.src1);
  assign ex_dst_c  = REG_ADDR_L'(ex_instr_q.dst);

  // Container bits above REG_ADDR_L are always zero.
  assign unused_addr_hi_c = ^{ex_instr_q.src0 >> REG_ADDR_L,
                              ex_instr_q.src1 >> REG_ADDR_L,
                              ex_instr_q.dst  >> REG_ADDR_L};

  pe_regfile #(
    .REG_N      (REG_N),
    .REG_ADDR_L (REG_ADDR_L)
  ) u_regfile (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .rd0_addr_i (ex_src0_c),
    .rd0_data_o (rf_rd0_c),
    .rd1_addr_i (ex_src1_c),
    .rd1_data_o (rf_rd1_c),
    .ld_we_i    (ld_we_c),
    .ld_addr_i  (ld_addr_i),
    .ld_data_i  (ld_data_i),
    .wb_we_i    (retire_c),
    .wb_addr_i  (wb_dst_q),
    .wb_data_i  (wb_data_q)
  );

  // WB holds the only result not yet in the register file, so it is the only bypass source.
  assign opnd0_c = (wb_vld_q && (wb_dst_q == ex_src0_c)) ? wb_data_q : rf_rd0_c;
  assign opnd1_c = (wb_vld_q && (wb_dst_q == ex_src1_c)) ? wb_data_q : rf_rd1_c;

  // Operator drive: quiet zeros whenever EX is empty or in reset.
  always_comb begin
    op_in_0_o   = '0;
    op_in_1_o   = '0;
    op_opcode_o = '0;
    if (ex_vld_q && !rst_i) begin
      op_in_0_o   = opnd0_c;
      op_in_1_o   = opnd1_c;
      op_opcode_o = ex_instr_q.opcode;
    end
  end

  // Pipeline advance; both stages freeze together on a stall.
  always_comb begin
    ex_vld_d   = ex_vld_q;
    ex_instr_d = ex_instr_q;
    wb_vld_d   = wb_vld_q;
    wb_store_d = wb_store_q;
    wb_data_d  = wb_data_q;
    wb_dst_d   = wb_dst_q;
    if (!stall_c) begin
      ex_vld_d = accept_c;
      if (accept_c) begin
        ex_instr_d = instr_c;
      end
      wb_vld_d = ex_vld_q;
      if (ex_vld_q) begin
        wb_data_d  = op_out_i;
        wb_dst_d   = ex_dst_c;
        wb_store_d = ex_instr_q.store;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_vld_q   <= 1'b0;
      ex_instr_q <= '0;
      wb_vld_q   <= 1'b0;
      wb_store_q <= 1'b0;
      wb_data_q  <= '0;
      wb_dst_q   <= '0;
    end else begin
      ex_vld_q   <= ex_vld_d;
      ex_instr_q <= ex_instr_d;
      wb_vld_q   <= wb_vld_d;
      wb_store_q <= wb_store_d;
      wb_data_q  <= wb_data_d;
      wb_dst_q   <= wb_dst_d;
    end
  end

  // Result stream is a direct view of WB, forced quiet while reset is held.
  assign res_vld_o  = !rst_i && wb_vld_q && wb_store_q;
  assign res_data_o = rst_i ? '0 : wb_data_q;
  assign res_dst_o  = rst_i ? '0 : wb_dst_q;
  assign busy_o     = !rst_i && (ex_vld_q || wb_vld_q);

endmodule

// File: tb/tb_pe_issue_ctrl.sv
// tb_pe_issue_ctrl: directed scenarios followed by random traffic for pe_issue_ctrl.
// The bench owns the PE operator and an architectural model: registers update in
// program order at acceptance, and store results are queued for the result stream.
module tb_pe_issue_ctrl;
  import pe_pkg::*;

  localparam int unsigned REG_N      = 16;
  localparam int unsigned REG_ADDR_L = 4;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  instr_vld;
  logic                  instr_rdy;
  logic [OPCODE_L-1:0]   instr_opcode;
  logic [REG_ADDR_L-1:0] instr_src0, instr_src1, instr_dst;
  logic                  instr_store;
  logic                  ld_vld;
  logic                  ld_rdy;
  logic [REG_ADDR_L-1:0] ld_addr;
  logic [DATA_L-1:0]     ld_data;
  logic [DATA_L-1:0]     op_in_0, op_in_1, op_out;
  logic [OPCODE_L-1:0]   op_opcode;
  logic                  res_vld;
  logic                  res_rdy;
  logic [DATA_L-1:0]     res_data;
  logic [REG_ADDR_L-1:0] res_dst;
  logic                  busy;

  typedef struct packed {
    logic [DATA_L-1:0]     data;
    logic [REG_ADDR_L-1:0] dst;
  } res_t;

  logic [DATA_L-1:0] m_reg [REG_N];
  res_t              exp_q [$];
  int                checks = 0;
  int                errors = 0;

  always #5 clk = ~clk;

  pe_issue_ctrl #(
    .REG_N      (REG_N),
    .REG_ADDR_L (REG_ADDR_L)
  ) dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .instr_vld_i    (instr_vld),
    .instr_rdy_o    (instr_rdy),
    .instr_opcode_i (instr_opcode),
    .instr_src0_i   (instr_src0),
    .instr_src1_i   (instr_src1),
    .instr_dst_i    (instr_dst),
    .instr_store_i  (instr_store),
    .ld_vld_i       (ld_vld),
    .ld_rdy_o       (ld_rdy),
    .ld_addr_i      (ld_addr),
    .ld_data_i      (ld_data),
    .op_in_0_o      (op_in_0),
    .op_in_1_o      (op_in_1),
    .op_opcode_o    (op_opcode),
    .op_out_i       (op_out),
    .res_vld_o      (res_vld),
    .res_rdy_i      (res_rdy),
    .res_data_o     (res_data),
    .res_dst_o      (res_dst),
    .busy_o         (busy)
  );

  function automatic logic [DATA_L-1:0] op_fn(input logic [OPCODE_L-1:0] opc,
                                              input logic [DATA_L-1:0] a,
                                              input logic [DATA_L-1:0] b);
    case (opc)
      OP_SUM:  return a + b;
      OP_PROD: return a * b;
      OP_PASS: return a;
      OP_MAX:  return (a > b) ? a : b;
      OP_MIN:  return (a < b) ? a : b;
      default: return '0;
    endcase
  endfunction

  assign op_out = op_fn(op_opcode, op_in_0, op_in_1);

  task automatic check(input string tag, input logic [DATA_L-1:0] obs, input logic [DATA_L-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%h expected 0x%h", tag, obs, exp);
    end
  endtask

  task automatic check1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Observe handshakes of the current cycle, update the model, advance one clock.
  task automatic step();
    res_t r;
    if (res_vld && res_rdy) begin
      if (exp_q.size() == 0) begin
        check1("res_spurious", res_vld, 1'b0);
      end else begin
        r = exp_q.pop_front();
        check("res_data", res_data, r.data);
        check("res_dst", DATA_L'(res_dst), DATA_L'(r.dst));
      end
    end
    if (rst) begin
      foreach (m_reg[i]) m_reg[i] = '0;
      exp_q.delete();
    end else begin
      if (instr_vld && instr_rdy) begin
        r.data = op_fn(instr_opcode, m_reg[instr_src0], m_reg[instr_src1]);
        r.dst  = instr_dst;
        m_reg[instr_dst] = r.data;
        if (instr_store) exp_q.push_back(r);
      end
      if (ld_vld && ld_rdy) m_reg[ld_addr] = ld_data;
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic cyc();
    #1;
    step();
  endtask

  task automatic idle();
    instr_vld    = 1'b0;
    instr_opcode = '0;
    instr_src0   = '0;
    instr_src1   = '0;
    instr_dst    = '0;
    instr_store  = 1'b0;
    ld_vld       = 1'b0;
    ld_addr      = '0;
    ld_data      = '0;
  endtask

  task automatic issue(input logic [OPCODE_L-1:0] opc, input int s0, input int s1, input int d,
                       input logic st);
    instr_vld    = 1'b1;
    instr_opcode = opc;
    instr_src0   = REG_ADDR_L'(s0);
    instr_src1   = REG_ADDR_L'(s1);
    instr_dst    = REG_ADDR_L'(d);
    instr_store  = st;
  endtask

  task automatic load(input int a, input logic [DATA_L-1:0] v);
    idle();
    ld_vld  = 1'b1;
    ld_addr = REG_ADDR_L'(a);
    ld_data = v;
    #1;
    check1("ld_rdy_idle", ld_rdy, 1'b1);
    step();
    idle();
  endtask

  // Read a register through PASS with store; result appears two cycles after acceptance.
  task automatic readback(input string tag, input int a, input logic [DATA_L-1:0] v);
    res_rdy = 1'b1;
    issue(OP_PASS, a, 0, a, 1'b1);
    cyc();
    idle();
    cyc();
    #1;
    check1({tag, "_vld"}, res_vld, 1'b1);
    check({tag, "_data"}, res_data, v);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    idle();
    rst     = 1'b1;
    res_rdy = 1'b1;
    @(negedge clk);

    // Outputs held quiet during reset, before and after the first edge.
    for (int k = 0; k < 2; k++) begin
      #1;
      check1("rst_instr_rdy", instr_rdy, 1'b0);
      check1("rst_ld_rdy", ld_rdy, 1'b0);
      check1("rst_res_vld", res_vld, 1'b0);
      check1("rst_busy", busy, 1'b0);
      check("rst_op_opcode", DATA_L'(op_opcode), '0);
      check("rst_op_in_0", op_in_0, '0);
      check("rst_res_data", res_data, '0);
      step();
    end
    rst = 1'b0;
    #1;
    check1("first_instr_rdy", instr_rdy, 1'b1);
    check1("first_ld_rdy", ld_rdy, 1'b1);
    step();

    // MAX with two-cycle result latency.
    load(1, 32'h5);
    load(2, 32'h3);
    issue(OP_MAX, 1, 2, 3, 1'b1);
    #1;
    check1("max_rdy", instr_rdy, 1'b1);
    step();
    idle();
    #1;
    check("max_ex_opcode", DATA_L'(op_opcode), DATA_L'(OP_MAX));
    check("max_ex_in0", op_in_0, 32'h5);
    check("max_ex_in1", op_in_1, 32'h3);
    check1("max_ex_res_vld", res_vld, 1'b0);
    check1("max_ex_busy", busy, 1'b1);
    step();
    #1;
    check1("max_wb_vld", res_vld, 1'b1);
    check("max_wb_data", res_data, 32'h5);
    check("max_wb_dst", DATA_L'(res_dst), 32'd3);
    step();
    #1;
    check1("max_done_vld", res_vld, 1'b0);
    check1("max_done_busy", busy, 1'b0);
    check("idle_op_in_0", op_in_0, '0);
    step();

    // Back-to-back PASS then MIN that consumes the PASS result through the bypass.
    issue(OP_PASS, 1, 0, 4, 1'b0);
    #1;
    check1("b2b_rdy0", instr_rdy, 1'b1);
    step();
    issue(OP_MIN, 4, 2, 5, 1'b1);
    #1;
    check1("b2b_rdy1", instr_rdy, 1'b1);
    check("b2b_pass_opcode", DATA_L'(op_opcode), DATA_L'(OP_PASS));
    check("b2b_pass_in0", op_in_0, 32'h5);
    step();
    idle();
    #1;
    check("b2b_min_opcode", DATA_L'(op_opcode), DATA_L'(OP_MIN));
    check("b2b_fwd_in0", op_in_0, 32'h5);
    check("b2b_min_in1", op_in_1, 32'h3);
    step();
    #1;
    check1("b2b_res_vld", res_vld, 1'b1);
    check("b2b_res_data", res_data, 32'h3);
    check("b2b_res_dst", DATA_L'(res_dst), 32'd5);
    step();

    // Backpressure: store result held for three cycles, whole pipe frozen.
    res_rdy = 1'b0;
    issue(OP_PASS, 1, 0, 6, 1'b1);
    cyc();
    issue(OP_SUM, 1, 2, 7, 1'b1);
    #1;
    check1("bp_rdy_before", instr_rdy, 1'b1);
    step();
    issue(OP_PROD, 1, 2, 8, 1'b0);
    for (int k = 0; k < 3; k++) begin
      #1;
      check1("bp_instr_rdy", instr_rdy, 1'b0);
      check1("bp_res_vld", res_vld, 1'b1);
      check("bp_res_data", res_data, 32'h5);
      check("bp_res_dst", DATA_L'(res_dst), 32'd6);
      check("bp_op_opcode", DATA_L'(op_opcode), DATA_L'(OP_SUM));
      check("bp_op_in0", op_in_0, 32'h5);
      check("bp_op_in1", op_in_1, 32'h3);
      step();
    end
    res_rdy = 1'b1;
    #1;
    check1("bp_release_rdy", instr_rdy, 1'b1);
    check("bp_release_data", res_data, 32'h5);
    step();
    idle();
    #1;
    check1("bp_sum_vld", res_vld, 1'b1);
    check("bp_sum_data", res_data, 32'h8);
    check("bp_sum_dst", DATA_L'(res_dst), 32'd7);
    check("bp_prod_opcode", DATA_L'(op_opcode), DATA_L'(OP_PROD));
    step();
    #1;
    check1("bp_prod_nostore", res_vld, 1'b0);
    check1("bp_prod_busy", busy, 1'b1);
    step();
    cyc();
    readback("rb_r8", 8, 32'hF);

    // Load refused while busy, accepted once the pipe drains.
    issue(OP_PASS, 2, 0, 9, 1'b0);
    cyc();
    idle();
    ld_vld  = 1'b1;
    ld_addr = 4'd10;
    ld_data = 32'hAA;
    #1;
    check1("ldbusy_rdy0", ld_rdy, 1'b0);
    check1("ldbusy_busy", busy, 1'b1);
    step();
    #1;
    check1("ldbusy_rdy1", ld_rdy, 1'b0);
    step();
    #1;
    check1("ldbusy_rdy2", ld_rdy, 1'b1);
    step();
    idle();
    readback("rb_r10", 10, 32'hAA);
    readback("rb_r9", 9, 32'h3);

    // Reset one cycle after acceptance discards the instruction.
    issue(OP_SUM, 1, 2, 11, 1'b1);
    cyc();
    idle();
    rst = 1'b1;
    #1;
    check1("midrst_res_vld", res_vld, 1'b0);
    check1("midrst_busy", busy, 1'b0);
    check("midrst_opcode", DATA_L'(op_opcode), '0);
    step();
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      #1;
      check1("postrst_res_vld", res_vld, 1'b0);
      check1("postrst_busy", busy, 1'b0);
      step();
    end
    readback("rb_r11", 11, 32'h0);

    // Unrecognised opcode produces 0 and writes it.
    load(1, 32'h5);
    issue(OPCODE_L'(7), 1, 1, 1, 1'b1);
    cyc();
    idle();
    cyc();
    #1;
    check1("undef_vld", res_vld, 1'b1);
    check("undef_data", res_data, '0);
    check("undef_dst", DATA_L'(res_dst), 32'd1);
    step();
    readback("rb_undef", 1, 32'h0);

    // Random traffic against the model.
    for (int n = 0; n < 600; n++) begin
      instr_vld    = ($urandom_range(0, 99) < 55);
      instr_opcode = OPCODE_L'($urandom_range(0, 7));
      instr_src0   = REG_ADDR_L'($urandom_range(0, REG_N - 1));
      instr_src1   = REG_ADDR_L'($urandom_range(0, REG_N - 1));
      instr_dst    = REG_ADDR_L'($urandom_range(0, REG_N - 1));
      instr_store  = 1'($urandom_range(0, 1));
      res_rdy      = ($urandom_range(0, 99) < 70);
      ld_vld       = ($urandom_range(0, 99) < 40);
      ld_addr      = REG_ADDR_L'($urandom_range(0, REG_N - 1));
      ld_data      = $urandom();
      rst          = ($urandom_range(0, 249) == 0);
      cyc();
    end

    // Drain, then read every register back through the result stream.
    idle();
    rst     = 1'b0;
    res_rdy = 1'b1;
    for (int k = 0; k < 20 && busy; k++) cyc();
    check1("drain_busy", busy, 1'b0);
    check("drain_queue", DATA_L'(exp_q.size()), '0);
    for (int i = 0; i < int'(REG_N); i++) begin
      issue(OP_PASS, i, 0, i, 1'b1);
      cyc();
    end
    idle();
    for (int k = 0; k < 4; k++) cyc();
    check("final_queue", DATA_L'(exp_q.size()), '0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pe_issue_ctrl.md
PE_ISSUE_CTRL -- requirements
Module: pe_issue_ctrl

Interface
REQ-001 Parameter REG_N, default 16: number of local operand registers.
REQ-002 Parameter REG_ADDR_L, default 4: register address width, equal to $clog2(REG_N).
REQ-003 clk  in  1  the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  reset, synchronous and active-high.
REQ-005 instr_vld  in  1  instruction offered.
REQ-006 instr_rdy  out  1  instruction accepted when instr_vld && instr_rdy.
REQ-007 instr_opcode  in  OPCODE_L  operation (SUM/PROD/PASS/MAX/MIN).
REQ-008 instr_src0, instr_src1, instr_dst  in  REG_ADDR_L each  operand and destination register addresses.
REQ-009 instr_store  in  1  result is also emitted on the res port.
REQ-010 ld_vld  in  1; ld_rdy  out  1; ld_addr  in  REG_ADDR_L; ld_data  in  DATA_L  external register load.
REQ-011 op_in_0, op_in_1  out  DATA_L; op_opcode  out  OPCODE_L  drive the PE operator.
REQ-012 op_out  in  DATA_L  combinational result returned by the PE operator.
REQ-013 res_vld  out  1; res_rdy  in  1; res_data  out  DATA_L; res_dst  out  REG_ADDR_L  result stream.
REQ-014 busy  out  1  asserted when EX or WB stage is valid.

Function
REQ-015 The block is a two-stage pipeline: EX (operator drive), then WB (result hold and register write).
REQ-016 An accepted instruction enters EX on the next cycle (ex_vld=1); op_* ports are driven during that cycle.
REQ-017 op_in_0/op_in_1 = regfile[src0]/regfile[src1], forwarded from wb_data when WB is valid and wb_dst equals the source address.
REQ-018 While ex_vld=0, op_in_0, op_in_1 and op_opcode are driven to 0.
REQ-019 At the end of the EX cycle, op_out, dst and store are captured into WB; result latency is 2 cycles from acceptance.
REQ-020 WB retires when wb_vld && (!wb_store || res_rdy); on retire, regfile[wb_dst] <= wb_data.
REQ-021 res_vld = wb_vld && wb_store; res_data/res_dst = wb_data/wb_dst; res_vld holds with stable data until res_rdy.
REQ-022 stall = wb_vld && wb_store && !res_rdy; on stall, EX and WB hold and instr_rdy=0.
REQ-023 instr_rdy = !stall; back-to-back issue gives one instruction per cycle.
REQ-024 ld_rdy = !ex_vld && !wb_vld && !instr_vld; loads are accepted only when the pipeline is empty and no instruction is offered.
REQ-025 An unrecognized opcode is passed through to the operator; its result (0) is written normally.
REQ-026 src equal to dst in the same instruction reads the old value.

Reset
REQ-027 While rst=1: ex_vld=0, wb_vld=0, res_vld=0, res_data=0, res_dst=0, all op_* outputs=0, busy=0, every register file entry=0.
REQ-028 While rst=1: instr_rdy=0 and ld_rdy=0.
REQ-029 rst asserted mid-operation discards in-flight instructions without any register write.
REQ-030 The first instruction is accepted on the cycle after rst deasserts.

Structure
REQ-031 Opcode encodings, DATA_L, OPCODE_L and PRECISION_CONFIG_L come from pe_pkg/common; the instruction struct (opcode, src0, src1, dst, store) is added to pe_pkg.
REQ-032 One sub-module is allowed: pe_regfile (REG_N x DATA_L, 2 async read ports, 2 sync write ports for load and WB).
REQ-033 precision_config is not handled here; the parent wires it to the operator directly.

Verification
REQ-034 Load r1=0x5, r2=0x3; issue MAX dst=r3 store=1, res_rdy=1 -> res_vld at acceptance+2, res_data=0x5, res_dst=3.
REQ-035 Back-to-back PASS r1->r4, then MIN src0=r4, src1=r2 dst=r5 store -> forwarded operand, res_data=0x3, no bubble.
REQ-036 res_rdy=0 for 3 cycles with a store result pending -> instr_rdy=0, res_data stable, op_* stable; release -> single transfer.
REQ-037 ld_vld while busy=1 -> ld_rdy=0 and no register change; retry when idle -> written.
REQ-038 rst pulsed one cycle after an instruction is accepted -> no res_vld, destination register reads 0 via later PASS store.
REQ-039 Undefined opcode, store=1 -> res_data=0, destination register=0.
